// File: rtl/dp_memory_pkg.sv
// rtl/dp_memory_pkg.sv - read-during-write encodings, clear FSM state type, byte-merge helper
package dp_memory_pkg;

    localparam bit WRITE_FIRST = 1'b0;
    localparam bit READ_FIRST  = 1'b1;

    // Widest word the merge helper handles; callers zero-extend and truncate around it.
    localparam int MERGE_WIDTH = 256;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clear_state_t;

    // Take new_word on every lane whose lane_mask bit is set, old_word elsewhere.
    function automatic logic [MERGE_WIDTH-1:0] byte_merge(
        input logic [MERGE_WIDTH-1:0] old_word,
        input logic [MERGE_WIDTH-1:0] new_word,
        input logic [MERGE_WIDTH-1:0] lane_mask,
        input int                     byte_width
    );
        logic [MERGE_WIDTH-1:0] merged;
        logic [7:0]             lane;
        merged = '0;
        for (int i = 0; i < MERGE_WIDTH; i++) begin
            lane      = 8'(i / byte_width);
            merged[i] = lane_mask[lane] ? new_word[i] : old_word[i];
        end
        return merged;
    endfunction

endpackage

// File: rtl/memory_clear_sequencer.sv
// rtl/memory_clear_sequencer.sv - zeroes every word once after reset, then reports ready
module memory_clear_sequencer
    import dp_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ready,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_address
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDRESS = '1;

    clear_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] counter, counter_next;

    // State and address counter; reset restarts clearing from word 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // Walk the counter through every word, then park in READY until the next reset.
    always_comb begin
        state_next    = state;
        counter_next  = counter;
        ready         = 1'b0;
        clear_we      = 1'b0;
        clear_address = counter;
        case (state)
            CLEAR: begin
                clear_we = 1'b1;
                if (counter == LAST_ADDRESS) begin
                    state_next = READY;
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
            READY: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dp_data_memory.sv
// rtl/dp_data_memory.sv - true dual-port byte-lane memory with power-up clear and collision flag
module dp_data_memory
    import dp_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter bit RDW_MODE   = WRITE_FIRST,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic                             clock,
    input  logic                             reset,
    output logic                             ready,
    input  logic                             req_a,
    input  logic                             write_enable_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_enable_a,
    input  logic [ADDR_WIDTH-1:0]            address_a,
    input  logic [DATA_WIDTH-1:0]            write_data_a,
    output logic [DATA_WIDTH-1:0]            read_data_a,
    output logic                             read_valid_a,
    input  logic                             req_b,
    input  logic                             write_enable_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_enable_b,
    input  logic [ADDR_WIDTH-1:0]            address_b,
    input  logic [DATA_WIDTH-1:0]            write_data_b,
    output logic [DATA_WIDTH-1:0]            read_data_b,
    output logic                             read_valid_b,
    output logic                             collision
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_address;

    logic                  accept_a, accept_b, write_a, write_b, collide;
    logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b, result_a, result_b;

    logic                  valid_a_s1, valid_b_s1, collision_s1;
    logic [DATA_WIDTH-1:0] data_a_s1, data_b_s1;

    memory_clear_sequencer #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear (
        .clock        (clock),
        .reset        (reset),
        .ready        (ready),
        .clear_we     (clear_we),
        .clear_address(clear_address)
    );

    // Accept decisions, collision detect and the word each port will return.
    always_comb begin
        accept_a = req_a && ready;
        accept_b = req_b && ready;
        write_a  = accept_a && write_enable_a;
        write_b  = accept_b && write_enable_b;
        collide  = write_a && write_b && (address_a == address_b);
        old_a    = ram[address_a];
        old_b    = ram[address_b];
        merged_a = DATA_WIDTH'(byte_merge(MERGE_WIDTH'(old_a), MERGE_WIDTH'(write_data_a),
                                          MERGE_WIDTH'(byte_enable_a), BYTE_WIDTH));
        merged_b = DATA_WIDTH'(byte_merge(MERGE_WIDTH'(old_b), MERGE_WIDTH'(write_data_b),
                                          MERGE_WIDTH'(byte_enable_b), BYTE_WIDTH));
        result_a = (write_enable_a && (RDW_MODE == WRITE_FIRST)) ? merged_a : old_a;
        result_b = (write_enable_b && (RDW_MODE == WRITE_FIRST)) ? merged_b : old_b;
    end

    // Storage: clear port while not ready, otherwise per-lane writes; port a wins a same-word clash.
    always_ff @(posedge clock) begin
        if (clear_we) begin
            ram[clear_address] <= '0;
        end
        for (int l = 0; l < NB; l++) begin
            if (write_a && byte_enable_a[l]) begin
                ram[address_a][l*BYTE_WIDTH +: BYTE_WIDTH] <= write_data_a[l*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (write_b && !collide && byte_enable_b[l]) begin
                ram[address_b][l*BYTE_WIDTH +: BYTE_WIDTH] <= write_data_b[l*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // First read stage; data only moves on an accepted access so it holds otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_a_s1   <= 1'b0;
            valid_b_s1   <= 1'b0;
            collision_s1 <= 1'b0;
            data_a_s1    <= '0;
            data_b_s1    <= '0;
        end else begin
            valid_a_s1   <= accept_a;
            valid_b_s1   <= accept_b;
            collision_s1 <= collide;
            if (accept_a) data_a_s1 <= result_a;
            if (accept_b) data_b_s1 <= result_b;
        end
    end

    if (OUT_REG) begin : g_out_reg
        // Optional output stage, flushed by reset like the first stage.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                read_valid_a <= 1'b0;
                read_valid_b <= 1'b0;
                collision    <= 1'b0;
                read_data_a  <= '0;
                read_data_b  <= '0;
            end else begin
                read_valid_a <= valid_a_s1;
                read_valid_b <= valid_b_s1;
                collision    <= collision_s1;
                if (valid_a_s1) read_data_a <= data_a_s1;
                if (valid_b_s1) read_data_b <= data_b_s1;
            end
        end
    end else begin : g_no_out_reg
        assign read_valid_a = valid_a_s1;
        assign read_valid_b = valid_b_s1;
        assign collision    = collision_s1;
        assign read_data_a  = data_a_s1;
        assign read_data_b  = data_b_s1;
    end

endmodule

// File: doc/dp_data_memory.md
DP_DATA_MEMORY -- requirements
Module: dp_data_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of BYTE_WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 16: depth is 2**ADDR_WIDTH words.
REQ-003 Parameter BYTE_WIDTH, default 8: byte-lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes.
REQ-004 Parameter RDW_MODE, default WRITE_FIRST: same-port read-during-write result, WRITE_FIRST or READ_FIRST.
REQ-005 Parameter OUT_REG, default 0: 1 adds an output register stage.
REQ-006 Ports SHALL be (x = a, b for the per-port signals):
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- ready  out  1  high once the clear sequence has finished; accesses are accepted only while high.
- req_x  in  1  access request.
- write_enable_x  in  1  1 = write, 0 = read.
- byte_enable_x  in  NB  write lane mask.
- address_x  in  ADDR_WIDTH  word address.
- write_data_x  in  DATA_WIDTH  write data.
- read_data_x  out  DATA_WIDTH  returned word.
- read_valid_x  out  1  one-cycle pulse qualifying read_data_x.
- collision  out  1  one-cycle pulse on a dropped port-b write.

Function
REQ-007 An access SHALL be accepted on a rising clock edge when req_x=1 and ready=1; otherwise it is ignored with no side effects.
REQ-008 A read SHALL return the addressed word with read_valid_x asserted L cycles after acceptance, where L=1+OUT_REG.
REQ-009 A write SHALL update only the lanes with byte_enable_x=1; other lanes SHALL keep their stored value.
REQ-010 A write SHALL also produce read_valid_x after L cycles: under WRITE_FIRST with the merged new word, under READ_FIRST with the pre-write word.
REQ-011 A write with byte_enable_x all-zero SHALL leave memory unchanged and still return the read data defined in REQ-010.
REQ-012 read_data_x SHALL hold its last value while read_valid_x=0.
REQ-013 Back-to-back accepted accesses SHALL be supported every cycle on both ports, with no bubbles.
REQ-014 Both ports writing the same address in the same cycle: port a's write SHALL take effect entirely, port b's write SHALL be dropped, and collision SHALL pulse L cycles later.
REQ-015 One port writing while the other reads the same address in the same cycle: the reader SHALL return the pre-write word.
REQ-016 Both ports reading the same address SHALL return identical data, with no collision pulse.
REQ-017 Clear FSM states SHALL be CLEAR and READY.
- In CLEAR, a counter starts at 0 and each cycle one word ram[counter] is written to 0, then the counter increments.
- When the counter reaches 2**ADDR_WIDTH-1 the FSM SHALL go to READY on the following edge, so ready rises 2**ADDR_WIDTH cycles after reset deasserts.
REQ-018 READY SHALL be terminal until reset is asserted; the counter SHALL not wrap or re-enter CLEAR by itself.
REQ-019 Any pipelined read_valid_x or collision still in flight when reset asserts SHALL be discarded.

Reset
REQ-020 Asserting reset SHALL asynchronously force:
- state=CLEAR, counter=0, ready=0;
- read_valid_a=read_valid_b=0, collision=0;
- read_data_a=read_data_b=0, including the OUT_REG stage.
REQ-021 Reset asserted mid-CLEAR SHALL restart clearing from address 0.
REQ-022 The memory array SHALL NOT be reset asynchronously; it is zeroed only by the CLEAR sequence.

Structure
REQ-023 Package dp_memory_pkg SHALL hold:
- the RDW_MODE encodings WRITE_FIRST=0 and READ_FIRST=1;
- the FSM state type (CLEAR, READY);
- a byte-merge helper function.
REQ-024 The clear FSM and its counter SHALL be a single sub-module, memory_clear_sequencer, with outputs ready, clear_we and clear_address.
REQ-025 The storage array SHALL be inferable as true dual-port block RAM with per-lane write enables.

Verification
REQ-026 Bench (ADDR_WIDTH=4, defaults otherwise): release reset -> ready=0 for 16 cycles, rises at cycle 16; every address then reads 0x0000.
REQ-027 Write a:0x3 data 0xABCD be=11, then write a:0x3 data 0x1234 be=01, then read a:0x3 -> 0xAB34, valid 1 cycle after the read (2 with OUT_REG=1).
REQ-028 Same cycle: write a:0x5=0x1111 and write b:0x5=0x2222 -> collision pulses once; a read of 0x5 returns 0x1111.
REQ-029 RDW_MODE=READ_FIRST with ram[7]=0x00FF, write a:0x7=0xFF00 be=11 -> read_data_a=0x00FF; WRITE_FIRST -> 0xFF00.
REQ-030 Same cycle: write a:0x2=0x5A5A while b reads 0x2 (old value 0x0000) -> read_data_b=0x0000; a later read of 0x2 returns 0x5A5A.
REQ-031 Assert reset at clear cycle 8, release -> ready rises 16 cycles after release; requests issued while ready=0 cause no valid pulses and no writes.
